frame_capture_buffer: RTL and testbench

Parametrised frame capture and readout buffer for the image-processing path. Hunts a two-byte start-of-frame marker in an 8-bit byte stream and stores the next IMG_WIDTH×IMG_HEIGHT pixels into an internal frame buffer. It then streams the stored frame out in raster order, with optional horizontal mirroring, over a valid/ready handshake. It sits between the raw bitstream source and downstream pixel consumers.

---
 rtl/frame_capture_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_frame_capture_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_buffer.sv
// Hunts an SOF_HI/SOF_LO marker, captures IMG_WIDTH x IMG_HEIGHT pixels, then streams the frame
// out in raster order (optionally mirrored per line) through a prefetching output stage.
module frame_capture_buffer #(
    parameter int         IMG_WIDTH  = 320,
    parameter int         IMG_HEIGHT = 240,
    parameter int         PIX_W      = 8,
    parameter logic [7:0] SOF_HI     = 8'hFF,
    parameter logic [7:0] SOF_LO     = 8'hD8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       bitstream,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mirror,
    output logic [PIX_W-1:0] image_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eol,
    output logic             out_last,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [1:0]       dbg_state_o
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(IMG_WIDTH);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
    localparam logic [AW-1:0] LAST_BASE  = AW'(NPIX - IMG_WIDTH);
    localparam logic [AW-1:0] WIDTH_A    = AW'(IMG_WIDTH);
    localparam logic [AW-1:0] LAST_COL_A = AW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_WIDTH - 1);

    // dbg_state_o encoding: 0 HUNT, 1 MARK2, 2 CAPTURE, 3 READ
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MARK2   = 2'd1,
        CAPTURE = 2'd2,
        READ    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              mirror_q, mirror_d;
    logic [CW-1:0]     col_q, col_d;
    logic [AW-1:0]     line_base_q, line_base_d;
    logic              rd_pend_q, rd_pend_d;
    logic              m_vld_q, m_vld_d;
    logic              m_eol_q, m_eol_d;
    logic              m_last_q, m_last_d;
    logic              o_vld_q, o_vld_d;
    logic [PIX_W-1:0]  o_data_q, o_data_d;
    logic              o_eol_q, o_eol_d;
    logic              o_last_q, o_last_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic [PIX_W-1:0]  mem [NPIX];
    logic [PIX_W-1:0]  rd_data_q;
    logic [PIX_W-1:0]  in_pix;

    logic              accept;
    logic              wr_en;
    logic              capture_done;
    logic              o_xfer;
    logic              last_xfer;
    logic              o_load;
    logic              m_free;
    logic              issue;
    logic              mirror_eff;
    logic [AW-1:0]     col_off;
    logic [AW-1:0]     rd_addr;
    logic              iss_eol;
    logic              iss_last;

    generate
        if (PIX_W > 8) begin : g_ext
            assign in_pix = {{(PIX_W - 8){1'b0}}, bitstream};
        end else begin : g_trunc
            assign in_pix = bitstream[PIX_W-1:0];
        end
    endgenerate

    // Both ports use valid/ready: a beat moves on a rising edge where valid & ready are high;
    // a held beat (valid=1, ready=0) keeps its data and sidebands unchanged.
    assign in_ready     = reset && (state_q != READ);
    assign accept       = in_valid && in_ready;
    assign wr_en        = accept && (state_q == CAPTURE);
    assign capture_done = wr_en && (wr_addr_q == LAST_ADDR);

    // Two-slot pipeline: rd_data_q (memory output) feeds the output register, so a new read
    // can be issued every cycle the downstream keeps accepting.
    assign o_xfer     = o_vld_q && out_ready;
    assign last_xfer  = o_xfer && o_last_q;
    assign o_load     = m_vld_q && (!o_vld_q || out_ready);
    assign m_free     = !m_vld_q || o_load;
    assign issue      = (capture_done || rd_pend_q) && m_free;

    // The first read is issued on the capture-complete edge, so mirror is used live there.
    assign mirror_eff = capture_done ? mirror : mirror_q;
    assign col_off    = mirror_eff ? (LAST_COL_A - AW'(col_q)) : AW'(col_q);
    assign rd_addr    = line_base_q + col_off;
    assign iss_eol    = (col_q == LAST_COL);
    assign iss_last   = iss_eol && (line_base_q == LAST_BASE);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        case (state_q)
            HUNT: begin
                if (accept && bitstream == SOF_HI) state_d = MARK2;
            end
            MARK2: begin
                if (accept) begin
                    if (bitstream == SOF_LO) begin
                        state_d   = CAPTURE;
                        wr_addr_d = '0;
                    end else if (bitstream != SOF_HI) begin
                        state_d = HUNT;
                    end
                end
            end
            CAPTURE: begin
                if (accept) begin
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = READ;
                        wr_addr_d = '0;
                    end
                end
            end
            READ: begin
                if (last_xfer) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        mirror_d      = mirror_eff;
        col_d         = col_q;
        line_base_d   = line_base_q;
        rd_pend_d     = rd_pend_q;
        m_vld_d       = m_vld_q;
        m_eol_d       = m_eol_q;
        m_last_d      = m_last_q;
        o_vld_d       = o_vld_q;
        o_data_d      = o_data_q;
        o_eol_d       = o_eol_q;
        o_last_d      = o_last_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        if (issue) begin
            m_vld_d   = 1'b1;
            m_eol_d   = iss_eol;
            m_last_d  = iss_last;
            rd_pend_d = !iss_last;
            if (iss_eol) begin
                col_d       = '0;
                line_base_d = iss_last ? '0 : (line_base_q + WIDTH_A);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (o_load) begin
            m_vld_d = 1'b0;
        end

        if (o_load) begin
            o_vld_d  = 1'b1;
            o_data_d = rd_data_q;
            o_eol_d  = m_eol_q;
            o_last_d = m_last_q;
        end else if (o_xfer) begin
            o_vld_d  = 1'b0;
            o_eol_d  = 1'b0;
            o_last_d = 1'b0;
        end

        if (last_xfer) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= HUNT;
            wr_addr_q     <= '0;
            mirror_q      <= 1'b0;
            col_q         <= '0;
            line_base_q   <= '0;
            rd_pend_q     <= 1'b0;
            m_vld_q       <= 1'b0;
            m_eol_q       <= 1'b0;
            m_last_q      <= 1'b0;
            o_vld_q       <= 1'b0;
            o_data_q      <= '0;
            o_eol_q       <= 1'b0;
            o_last_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            mirror_q      <= mirror_d;
            col_q         <= col_d;
            line_base_q   <= line_base_d;
            rd_pend_q     <= rd_pend_d;
            m_vld_q       <= m_vld_d;
            m_eol_q       <= m_eol_d;
            m_last_q      <= m_last_d;
            o_vld_q       <= o_vld_d;
            o_data_q      <= o_data_d;
            o_eol_q       <= o_eol_d;
            o_last_q      <= o_last_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Frame storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q] <= in_pix;
        if (issue) rd_data_q <= mem[rd_addr];
    end

    assign image_out   = o_data_q;
    assign out_valid   = o_vld_q;
    assign out_eol     = o_eol_q;
    assign out_last    = o_last_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed bench for frame_capture_buffer on a 4x2 frame: capture, mirrored readout, marker
// hunting, backpressure, input gating during readout and reset in mid-capture.
module tb_frame_capture_buffer;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk;
    logic        reset;
    logic [7:0]  bitstream;
    logic        in_valid;
    logic        in_ready;
    logic        mirror;
    logic [7:0]  image_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_eol;
    logic        out_last;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [1:0]  dbg_state;

    int          n_total;
    int          n_bad;

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_pix[$];
    logic        got_eol[$];
    logic        got_last[$];
    int          first_valid_k;
    int          last_k;
    int          stall_cnt;
    int          stall_bad;
    bit          timed_out;

    frame_capture_buffer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (8),
        .SOF_HI    (8'hFF),
        .SOF_LO    (8'hD8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bitstream  (bitstream),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mirror     (mirror),
        .image_out  (image_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .dbg_state_o(dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    // driver: sends every byte in tx_q, optionally with idle gaps carrying junk data
    task automatic drive_tx(input bit gaps);
        while (tx_q.size() > 0) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid  = 1'b0;
                bitstream = 8'($urandom_range(0, 255));
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            in_valid  = 1'b1;
            bitstream = tx_q.pop_front();
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // monitor: mode 0 keeps out_ready high, mode 1 cycles it 1,0,0,1
    task automatic collect_frame(input int mode, input int budget);
        logic       rdy;
        logic       pv, pe, pl;
        logic [7:0] pp;
        bit         prev_stall;
        got_pix.delete();
        got_eol.delete();
        got_last.delete();
        first_valid_k = -1;
        last_k        = -1;
        stall_cnt     = 0;
        stall_bad     = 0;
        timed_out     = 1'b1;
        prev_stall    = 1'b0;
        pv = 1'b0; pe = 1'b0; pl = 1'b0; pp = '0;
        for (int k = 0; k < budget; k++) begin
            rdy = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            out_ready = rdy;
            if (out_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
            if (prev_stall) begin
                stall_cnt++;
                if ({out_valid, image_out, out_eol, out_last} !== {pv, pp, pe, pl}) stall_bad++;
            end
            prev_stall = (out_valid === 1'b1) && !rdy;
            pv = out_valid; pp = image_out; pe = out_eol; pl = out_last;
            if (out_valid === 1'b1 && rdy) begin
                got_pix.push_back(image_out);
                got_eol.push_back(out_eol);
                got_last.push_back(out_last);
                if (out_last === 1'b1) begin
                    last_k    = k;
                    timed_out = 1'b0;
                    @(negedge clk);
                    return;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mirror = 1'b0; bitstream = 8'h00;
        repeat (2) @(negedge clk);
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_total++; if (out_eol !== 1'b0 || out_last !== 1'b0) begin n_bad++; $display("FAIL reset_eol_last: got %b%b want 00", out_eol, out_last); end
        n_total++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_total++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_total++; if (image_out !== 8'h00) begin n_bad++; $display("FAIL reset_image_out: got %h want 00", image_out); end
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        tx_q  = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drive_tx(1'b0);
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_read: got %b want 0", in_ready); end
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        collect_frame(0, 40);
        n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
        n_total++; if (first_valid_k !== 1) begin n_bad++; $display("FAIL basic_latency: got %0d want 1", first_valid_k); end
        n_total++; if (last_k - first_valid_k !== W * H - 1) begin n_bad++; $display("FAIL basic_bubbles: got %0d want %0d", last_k - first_valid_k, W * H - 1); end
        n_total++; if (got_pix.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", got_pix.size(), exp_q.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_pix[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_pix[%0d]: got %h want %h", i, got_pix[i], exp_q[i]); end
            n_total++; if (got_eol[i] !== ((i % W == W - 1) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL basic_eol[%0d]: got %b", i, got_eol[i]); end
            n_total++; if (got_last[i] !== ((i == W * H - 1) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b", i, got_last[i]); end
        end
        n_total++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL basic_frame_done: got %b want 1", frame_done); end
        n_total++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL basic_frame_count: got %0d want 1", frame_count); end
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_after: got %b want 0", out_valid); end
        n_total++; if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL basic_hunt_after: got ready=%b state=%0d want 1/0", in_ready, dbg_state); end
        @(negedge clk);
        n_total++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_mirror();
        mirror = 1'b1;
        tx_q  = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
        drive_tx(1'b0);
        mirror = 1'b0;
        collect_frame(0, 40);
        n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL mirror_timeout: got %b want 0", timed_out); end
        n_total++; if (first_valid_k !== 1) begin n_bad++; $display("FAIL mirror_latency: got %0d want 1", first_valid_k); end
        n_total++; if (got_pix.size() !== exp_q.size()) begin n_bad++; $display("FAIL mirror_count: got %0d want %0d", got_pix.size(), exp_q.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_pix[i] !== exp_q[i]) begin n_bad++; $display("FAIL mirror_pix[%0d]: got %h want %h", i, got_pix[i], exp_q[i]); end
            n_total++; if (got_eol[i] !== ((i % W == W - 1) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL mirror_eol[%0d]: got %b", i, got_eol[i]); end
            n_total++; if (got_last[i] !== ((i == W * H - 1) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL mirror_last[%0d]: got %b", i, got_last[i]); end
        end
        n_total++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL mirror_frame_done: got %b want 1", frame_done); end
        n_total++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL mirror_frame_count: got %0d want 2", frame_count); end
    endtask

    task automatic test_markers();
        tx_q = '{8'hFF, 8'h00, 8'hD8};
        drive_tx(1'b0);
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL marker_ff00d8: got state %0d want 0", dbg_state); end
        tx_q = '{8'hFF, 8'hFF};
        drive_tx(1'b0);
        n_total++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL marker_ffff: got state %0d want 1", dbg_state); end
        tx_q = '{8'hD8};
        drive_tx(1'b0);
        n_total++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL marker_ffffd8: got state %0d want 2", dbg_state); end
        tx_q  = '{8'h21, 8'hFF, 8'hD8, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        exp_q = '{8'h21, 8'hFF, 8'hD8, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        drive_tx(1'b0);
        n_total++; if (dbg_state !== 2'd3) begin n_bad++; $display("FAIL marker_payload_state: got %0d want 3", dbg_state); end
        collect_frame(0, 40);
        n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL marker_timeout: got %b want 0", timed_out); end
        n_total++; if (got_pix.size() !== exp_q.size()) begin n_bad++; $display("FAIL marker_count: got %0d want %0d", got_pix.size(), exp_q.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_pix[i] !== exp_q[i]) begin n_bad++; $display("FAIL marker_pix[%0d]: got %h want %h", i, got_pix[i], exp_q[i]); end
        end
        n_total++; if (frame_count !== 16'd3) begin n_bad++; $display("FAIL marker_frame_count: got %0d want 3", frame_count); end
    endtask

    task automatic test_backpressure();
        tx_q  = '{8'hFF, 8'hD8, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        drive_tx(1'b1);
        collect_frame(1, 100);
        n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
        n_total++; if (got_pix.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", got_pix.size(), exp_q.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_pix[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_pix[%0d]: got %h want %h", i, got_pix[i], exp_q[i]); end
            n_total++; if (got_eol[i] !== ((i % W == W - 1) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL bp_eol[%0d]: got %b", i, got_eol[i]); end
            n_total++; if (got_last[i] !== ((i == W * H - 1) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b", i, got_last[i]); end
        end
        n_total++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", stall_bad); end
        n_total++; if (stall_cnt < 1) begin n_bad++; $display("FAIL bp_stall_seen: got %0d stalled cycles want >0", stall_cnt); end
        n_total++; if (frame_count !== 16'd4) begin n_bad++; $display("FAIL bp_frame_count: got %0d want 4", frame_count); end
        out_ready = 1'b1;
    endtask

    task automatic test_read_ignores_input();
        tx_q  = '{8'hFF, 8'hD8, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
        drive_tx(1'b0);
        in_valid  = 1'b1;
        bitstream = 8'hEE;
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rd_in_ready: got %b want 0", in_ready); end
        collect_frame(0, 40);
        in_valid = 1'b0;
        n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL rd_timeout: got %b want 0", timed_out); end
        n_total++; if (got_pix.size() !== exp_q.size()) begin n_bad++; $display("FAIL rd_count: got %0d want %0d", got_pix.size(), exp_q.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_pix[i] !== exp_q[i]) begin n_bad++; $display("FAIL rd_pix[%0d]: got %h want %h", i, got_pix[i], exp_q[i]); end
        end
        n_total++; if (frame_count !== 16'd5) begin n_bad++; $display("FAIL rd_frame_count: got %0d want 5", frame_count); end
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rd_state_after: got %0d want 0", dbg_state); end
    endtask

    task automatic test_reset_mid_capture();
        tx_q = '{8'hFF, 8'hD8, 8'h51, 8'h52, 8'h53};
        drive_tx(1'b0);
        n_total++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL midrst_pre_state: got %0d want 2", dbg_state); end
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        n_total++; if (out_valid !== 1'b0 || out_eol !== 1'b0 || out_last !== 1'b0) begin n_bad++; $display("FAIL midrst_out: got %b%b%b want 000", out_valid, out_eol, out_last); end
        n_total++; if (frame_count !== 16'd0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL midrst_count: got %0d/%b want 0/0", frame_count, frame_done); end
        n_total++; if (image_out !== 8'h00) begin n_bad++; $display("FAIL midrst_image_out: got %h want 00", image_out); end
        reset = 1'b1;
        @(negedge clk);
        tx_q  = '{8'hFF, 8'hD8, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        drive_tx(1'b0);
        collect_frame(0, 40);
        n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL midrst_timeout: got %b want 0", timed_out); end
        n_total++; if (got_pix.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_frame_size: got %0d want %0d", got_pix.size(), exp_q.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_q.size(); i++) begin
            n_total++; if (got_pix[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_pix[%0d]: got %h want %h", i, got_pix[i], exp_q[i]); end
        end
        n_total++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL midrst_frame_count: got %0d want 1", frame_count); end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        bitstream = 8'h00;
        mirror    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_mirror();
        test_markers();
        test_backpressure();
        test_read_ignores_input();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
